// File: rtl/pw_utmi_tx_pkg.sv
// Shared definitions for the UTMI transmit engine: PHY OpMode encodings and
// the transmit FSM state encoding.
package pw_utmi_tx_pkg;

  // UTMI OpMode[1:0] encodings driven toward the PHY.
  localparam logic [1:0] OPMODE_NORMAL     = 2'b00;
  localparam logic [1:0] OPMODE_NONDRIVING = 2'b01;

  // Transmit FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUS = 3'd1,
    ST_SETUP    = 3'd2,
    ST_SEND     = 3'd3,
    ST_RELEASE  = 3'd4
  } tx_state_e;

endpackage : pw_utmi_tx_pkg

// File: rtl/pw_tx_buffer.sv
// Packet buffer for the UTMI transmit engine: DEPTH x 8 distributed RAM with
// a synchronous write port and an asynchronous read port.
module pw_tx_buffer #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  logic [7:0] mem [DEPTH];

  // Host-side byte write.
  // NOTE: the array has no reset; clearing a RAM needs one write per word and
  // would stop it mapping onto distributed RAM cells. Contents are undefined
  // until the host loads them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : pw_tx_buffer

// File: rtl/pw_utmi_tx.sv
// UTMI transmit engine. Sends a host-loaded packet over the TxValid/TxReady
// handshake after the receive side has been quiet long enough, switching the
// PHY into normal OpMode only for the duration of the transmission.
module pw_utmi_tx
  import pw_utmi_tx_pkg::*;
#(
  parameter int pBUF_BYTES     = 64,
  parameter int pIDLE_CYCLES   = 8,
  parameter int pTXRDY_TIMEOUT = 1024
) (
  input  logic                          fe_clk,
  input  logic                          reset_i,
  input  logic                          I_buf_wr,
  input  logic [$clog2(pBUF_BYTES)-1:0] I_buf_addr,
  input  logic [7:0]                    I_buf_data,
  input  logic [$clog2(pBUF_BYTES):0]   I_len,
  input  logic                          I_start,
  input  logic                          I_abort,
  input  logic                          fe_rxactive,
  input  logic                          fe_txrdy,
  output logic [7:0]                    O_tx_data,
  output logic                          O_txvalid,
  output logic [1:0]                    O_opmode,
  output logic                          O_busy,
  output logic                          O_done,
  output logic                          O_error
);

  localparam int AW = $clog2(pBUF_BYTES);
  localparam int IW = $clog2(pIDLE_CYCLES) + 1;
  localparam int SW = $clog2(pTXRDY_TIMEOUT) + 1;

  localparam logic [AW:0]   LEN_MAX     = (AW + 1)'(pBUF_BYTES);
  localparam logic [IW-1:0] IDLE_TARGET = IW'(pIDLE_CYCLES);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(pTXRDY_TIMEOUT);

  tx_state_e     state;
  tx_state_e     state_next;

  logic [AW:0]   len_q;
  logic [AW-1:0] idx_q;
  logic [IW-1:0] idle_cnt;
  logic [SW-1:0] stall_cnt;
  logic          done_ok_q;      // this packet ends with a done pulse

  logic [AW:0]   len_clamped;
  logic [IW-1:0] idle_cnt_next;
  logic [SW-1:0] stall_cnt_next;
  logic          accept;
  logic          last_byte;
  logic          idle_reached;
  logic          stall_expired;

  logic          txvalid_d;
  logic [1:0]    opmode_d;
  logic          busy_d;
  logic          done_d;
  logic          error_d;

  logic [7:0]    rd_data;

  // Buffer: host writes are accepted only while idle; read at the send index.
  pw_tx_buffer #(
    .DEPTH (pBUF_BYTES)
  ) u_buffer (
    .clk     (fe_clk),
    .wr_en   (I_buf_wr && (state == ST_IDLE)),
    .wr_addr (I_buf_addr),
    .wr_data (I_buf_data),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

  // Handshake decode and saturating counter increments.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here by assigning it first); a path that leaves one unassigned infers a latch.
  always_comb begin
    len_clamped = (I_len > LEN_MAX) ? LEN_MAX : I_len;
    accept      = (state == ST_SEND) && fe_txrdy;
    last_byte   = ({1'b0, idx_q} == (len_q - 1'b1));

    idle_cnt_next = idle_cnt;
    if (fe_rxactive) begin
      idle_cnt_next = '0;
    end else if (idle_cnt != '1) begin
      idle_cnt_next = idle_cnt + 1'b1;
    end
    idle_reached = (idle_cnt_next >= IDLE_TARGET);

    stall_cnt_next = stall_cnt;
    if (accept) begin
      stall_cnt_next = '0;
    end else if ((state == ST_SEND) && (stall_cnt != '1)) begin
      stall_cnt_next = stall_cnt + 1'b1;
    end
    stall_expired = (state == ST_SEND) && !fe_txrdy && (stall_cnt_next >= STALL_LIMIT);
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // values from before the edge, whatever order the blocks are evaluated in.
  always_ff @(posedge fe_clk or negedge reset_i) begin
    if (!reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort takes priority over completion and timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (I_start) begin
          state_next = (len_clamped == '0) ? ST_RELEASE : ST_WAIT_BUS;
        end
      end
      ST_WAIT_BUS: begin
        if (I_abort) begin
          state_next = ST_RELEASE;
        end else if (idle_reached) begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_next = I_abort ? ST_RELEASE : ST_SEND;
      end
      ST_SEND: begin
        if (I_abort || (accept && last_byte) || stall_expired) begin
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Next values for the registered PHY-facing and status outputs.
  always_comb begin
    txvalid_d = (state_next == ST_SEND);
    busy_d    = (state_next != ST_IDLE);
    done_d    = (state == ST_RELEASE) && done_ok_q;
    error_d   = stall_expired && !I_abort;
    case (state_next)
      ST_SETUP, ST_SEND: opmode_d = OPMODE_NORMAL;
      ST_RELEASE:        opmode_d = O_opmode;   // hold whatever mode was in use
      default:           opmode_d = OPMODE_NONDRIVING;
    endcase
  end

  // Output registers.
  always_ff @(posedge fe_clk or negedge reset_i) begin
    if (!reset_i) begin
      O_txvalid <= 1'b0;
      O_opmode  <= OPMODE_NONDRIVING;
      O_busy    <= 1'b0;
      O_done    <= 1'b0;
      O_error   <= 1'b0;
    end else begin
      O_txvalid <= txvalid_d;
      O_opmode  <= opmode_d;
      O_busy    <= busy_d;
      O_done    <= done_d;
      O_error   <= error_d;
    end
  end

  // Packet length, byte index, idle/stall counters and completion flag.
  always_ff @(posedge fe_clk or negedge reset_i) begin
    if (!reset_i) begin
      len_q     <= '0;
      idx_q     <= '0;
      idle_cnt  <= '0;
      stall_cnt <= '0;
      done_ok_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx_q     <= '0;
          idle_cnt  <= '0;
          stall_cnt <= '0;
          if (I_start) begin
            len_q     <= len_clamped;
            done_ok_q <= (len_clamped == '0);
          end
        end
        ST_WAIT_BUS: begin
          idle_cnt <= idle_cnt_next;
        end
        ST_SEND: begin
          stall_cnt <= stall_cnt_next;
          if (accept) begin
            idx_q <= idx_q + 1'b1;
            if (last_byte && !I_abort) begin
              done_ok_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Data toward the PHY is the buffer byte while sending, zero otherwise.
  assign O_tx_data = (state == ST_SEND) ? rd_data : 8'h00;

endmodule : pw_utmi_tx

// File: tb/tb_pw_utmi_tx.sv
// Self-checking bench for pw_utmi_tx. A behavioural model derives, from the
// packet length, the bus-activity and TxReady sequences and any abort, the
// cycle numbers of each protocol event and from them the expected value of
// every output on every cycle of a transfer.
module tb_pw_utmi_tx;

  localparam int BUF      = 64;
  localparam int IDLE     = 8;
  localparam int TMO      = 1024;
  localparam int MAXC     = 1300;
  localparam int NO_ABORT = 100000;
  localparam int K_DONE   = 0;
  localparam int K_ABORT  = 1;
  localparam int K_ERR    = 2;

  // Output vector layout: {txvalid, opmode[1:0], busy, done, error, data[7:0]}
  localparam int B_TXV  = 13;
  localparam int B_BUSY = 10;
  localparam int B_DONE = 9;
  localparam int B_ERR  = 8;
  localparam logic [13:0] IDLE_VEC = {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00};

  logic       fe_clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       I_buf_wr = 1'b0;
  logic [5:0] I_buf_addr = '0;
  logic [7:0] I_buf_data = '0;
  logic [6:0] I_len = '0;
  logic       I_start = 1'b0;
  logic       I_abort = 1'b0;
  logic       fe_rxactive = 1'b0;
  logic       fe_txrdy = 1'b0;
  logic [7:0] O_tx_data;
  logic       O_txvalid;
  logic [1:0] O_opmode;
  logic       O_busy;
  logic       O_done;
  logic       O_error;

  pw_utmi_tx #(
    .pBUF_BYTES     (BUF),
    .pIDLE_CYCLES   (IDLE),
    .pTXRDY_TIMEOUT (TMO)
  ) dut (
    .fe_clk      (fe_clk),
    .reset_i     (reset_i),
    .I_buf_wr    (I_buf_wr),
    .I_buf_addr  (I_buf_addr),
    .I_buf_data  (I_buf_data),
    .I_len       (I_len),
    .I_start     (I_start),
    .I_abort     (I_abort),
    .fe_rxactive (fe_rxactive),
    .fe_txrdy    (fe_txrdy),
    .O_tx_data   (O_tx_data),
    .O_txvalid   (O_txvalid),
    .O_opmode    (O_opmode),
    .O_busy      (O_busy),
    .O_done      (O_done),
    .O_error     (O_error)
  );

  always #5 fe_clk = ~fe_clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem_model [BUF];
  bit          rx_seq  [MAXC];
  bit          rdy_seq [MAXC];
  logic [13:0] exp_vec [MAXC];
  logic [13:0] obs_vec [MAXC];
  int          exp_f, exp_rel, exp_kind, exp_abort_c, n_run;

  function automatic logic [13:0] cur_vec();
    return {O_txvalid, O_opmode, O_busy, O_done, O_error, O_tx_data};
  endfunction

  function automatic int first_obs(input int bitpos);
    for (int c = 0; c < n_run; c++) if (obs_vec[c][bitpos]) return c;
    return -1;
  endfunction

  function automatic int count_obs(input int bitpos);
    int n = 0;
    for (int c = 0; c < n_run; c++) if (obs_vec[c][bitpos]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic write_byte(input int addr, input logic [7:0] data);
    I_buf_wr   = 1'b1;
    I_buf_addr = 6'(addr);
    I_buf_data = data;
    tick();
    I_buf_wr   = 1'b0;
    mem_model[addr] = data;
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) write_byte(i, 8'($urandom));
  endtask

  task automatic clear_seqs();
    for (int i = 0; i < MAXC; i++) begin
      rx_seq[i]  = 1'b0;
      rdy_seq[i] = 1'b1;
    end
  endtask

  // Event-level model: find when the bus has been quiet for IDLE cycles,
  // walk the TxReady sequence counting accepts and stalls, and then paint
  // the expected outputs between those event cycles. Cycle 0 samples start.
  task automatic build_model(input int len_req, input int abort_rel);
    int l, run, setup_c, f, rel, n, stall, a, sent;
    bit txv, busy, done, err;
    logic [1:0] opm;
    logic [7:0] data;
    l = (len_req > BUF) ? BUF : len_req;
    setup_c = -1; f = -1; rel = -1; a = NO_ABORT; exp_kind = K_DONE;
    if (l == 0) begin
      rel = 1;
    end else begin
      run = 0;
      for (int c = 1; c < MAXC && setup_c < 0; c++) begin
        run = rx_seq[c] ? 0 : run + 1;
        if (run == IDLE) setup_c = c + 1;
      end
      if (abort_rel != NO_ABORT) a = setup_c + 1 + abort_rel;
      if (a <= setup_c) begin
        rel = a + 1;
        exp_kind = K_ABORT;
        if (a < setup_c) setup_c = -1;
      end else begin
        f = setup_c + 1; n = 0; stall = 0;
        for (int k = f; k < MAXC - 8 && rel < 0; k++) begin
          if (k == a) begin
            rel = k + 1; exp_kind = K_ABORT;
          end else if (rdy_seq[k - f]) begin
            n++; stall = 0;
            if (n == l) begin rel = k + 1; exp_kind = K_DONE; end
          end else begin
            stall++;
            if (stall == TMO) begin rel = k + 1; exp_kind = K_ERR; end
          end
        end
      end
    end
    if (rel < 0) rel = MAXC - 8;
    sent = 0;
    for (int c = 0; c < MAXC; c++) begin
      txv  = (f > 0) && (c >= f) && (c < rel);
      opm  = ((setup_c > 0) && (c >= setup_c) && (c <= rel)) ? 2'b00 : 2'b01;
      busy = (c >= 1) && (c <= rel);
      done = (exp_kind == K_DONE) && (c == rel + 1);
      err  = (exp_kind == K_ERR) && (c == rel);
      data = txv ? mem_model[sent] : 8'h00;
      if (txv && rdy_seq[c - f]) sent++;
      exp_vec[c] = {txv, opm, busy, done, err, data};
    end
    exp_f = f; exp_rel = rel; exp_abort_c = a; n_run = rel + 4;
  endtask

  // Drives one transfer cycle by cycle and records the outputs mid-cycle.
  // With scribble set it also writes the buffer, re-pulses start while busy
  // and pulses abort during RELEASE; all of that must be ignored.
  task automatic run_dut(input int len, input bit scribble);
    for (int c = 0; c < n_run; c++) begin
      I_start     = (c == 0) || (scribble && c == 3);
      I_len       = (c == 0) ? 7'(len) : 7'($urandom);
      I_abort     = (c == exp_abort_c) || (scribble && c == exp_rel);
      fe_rxactive = rx_seq[c];
      fe_txrdy    = (exp_f > 0 && c >= exp_f) ? rdy_seq[c - exp_f] : 1'($urandom);
      I_buf_wr    = scribble && (c >= 1) && (c <= exp_rel);
      I_buf_addr  = 6'($urandom);
      I_buf_data  = 8'($urandom);
      #1;
      obs_vec[c] = cur_vec();
      tick();
    end
    I_start = 1'b0; I_abort = 1'b0; I_buf_wr = 1'b0;
    fe_rxactive = 1'b0; fe_txrdy = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] v;
    reset_i = 1'b0;
    repeat (3) tick();
    v = cur_vec();
    checks++;
    if (v !== IDLE_VEC) begin
      errors++; $display("FAIL reset_held: got %h want %h", v, IDLE_VEC);
    end
    reset_i = 1'b1;
    tick();
    v = cur_vec();
    checks++;
    if (v !== IDLE_VEC) begin
      errors++; $display("FAIL reset_release: got %h want %h", v, IDLE_VEC);
    end
  endtask

  task automatic test_basic();
    logic [7:0] want [3];
    int fv, dc;
    want[0] = 8'h2D; want[1] = 8'h00; want[2] = 8'h10;
    for (int i = 0; i < 3; i++) write_byte(i, want[i]);
    clear_seqs();
    build_model(3, NO_ABORT);
    run_dut(3, 1'b0);
    for (int c = 0; c < n_run; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++; $display("FAIL basic cycle %0d: got %h want %h", c, obs_vec[c], exp_vec[c]);
      end
    end
    fv = first_obs(B_TXV);
    checks++;
    if (fv != 10) begin errors++; $display("FAIL basic_first_valid: got %0d want 10", fv); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_vec[10 + i][7:0] !== want[i]) begin
        errors++; $display("FAIL basic_byte%0d: got %h want %h", i, obs_vec[10 + i][7:0], want[i]);
      end
    end
    dc = first_obs(B_DONE);
    checks++;
    if (dc != 14) begin errors++; $display("FAIL basic_done_cycle: got %0d want 14", dc); end
    checks++;
    if (obs_vec[14][12:11] !== 2'b01) begin
      errors++; $display("FAIL basic_opmode_back: got %b want 01", obs_vec[14][12:11]);
    end
  endtask

  task automatic test_txrdy_toggle();
    int ns, ne;
    load_random(4);
    clear_seqs();
    for (int k = 0; k < MAXC; k++) rdy_seq[k] = (k % 2) == 1;
    build_model(4, NO_ABORT);
    run_dut(4, 1'b0);
    for (int c = 0; c < n_run; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++; $display("FAIL toggle cycle %0d: got %h want %h", c, obs_vec[c], exp_vec[c]);
      end
    end
    ns = count_obs(B_TXV);
    ne = count_obs(B_ERR);
    checks++;
    if (ns != 8) begin errors++; $display("FAIL toggle_send_cycles: got %0d want 8", ns); end
    checks++;
    if (ne != 0) begin errors++; $display("FAIL toggle_error: got %0d pulses want 0", ne); end
  endtask

  task automatic test_rx_restart();
    int fv;
    load_random(2);
    clear_seqs();
    rx_seq[6] = 1'b1;
    build_model(2, NO_ABORT);
    run_dut(2, 1'b0);
    for (int c = 0; c < n_run; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++; $display("FAIL rx_restart cycle %0d: got %h want %h", c, obs_vec[c], exp_vec[c]);
      end
    end
    fv = first_obs(B_TXV);
    checks++;
    if (fv != 16) begin errors++; $display("FAIL rx_restart_first_valid: got %0d want 16", fv); end
  endtask

  task automatic test_timeout();
    int ec, nd;
    load_random(5);
    clear_seqs();
    for (int k = 0; k < MAXC; k++) rdy_seq[k] = 1'b0;
    build_model(5, NO_ABORT);
    run_dut(5, 1'b0);
    for (int c = 0; c < n_run; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++; $display("FAIL timeout cycle %0d: got %h want %h", c, obs_vec[c], exp_vec[c]);
      end
    end
    ec = first_obs(B_ERR);
    nd = count_obs(B_DONE);
    checks++;
    if (ec != 10 + TMO) begin errors++; $display("FAIL timeout_error_cycle: got %0d want %0d", ec, 10 + TMO); end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL timeout_done: got %0d pulses want 0", nd); end
    checks++;
    if (obs_vec[11 + TMO][B_BUSY] !== 1'b0) begin
      errors++; $display("FAIL timeout_busy_clear: got %b want 0", obs_vec[11 + TMO][B_BUSY]);
    end
    // Abort landing on the expiring stall cycle suppresses the error pulse.
    build_model(5, TMO - 1);
    run_dut(5, 1'b0);
    ne_check: begin
      int n_err;
      n_err = count_obs(B_ERR);
      checks++;
      if (n_err != 0) begin errors++; $display("FAIL timeout_abort_error: got %0d pulses want 0", n_err); end
    end
    for (int c = 0; c < n_run; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++; $display("FAIL timeout_abort cycle %0d: got %h want %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_abort();
    int abort_rels [3];
    int lens [3];
    abort_rels[0] = 2;  lens[0] = 10;  // after two bytes of ten
    abort_rels[1] = 2;  lens[1] = 3;   // together with the last accept
    abort_rels[2] = -5; lens[2] = 4;   // while waiting for the bus
    load_random(10);
    for (int t = 0; t < 3; t++) begin
      clear_seqs();
      build_model(lens[t], abort_rels[t]);
      run_dut(lens[t], 1'b0);
      for (int c = 0; c < n_run; c++) begin
        checks++;
        if (obs_vec[c] !== exp_vec[c]) begin
          errors++; $display("FAIL abort%0d cycle %0d: got %h want %h", t, c, obs_vec[c], exp_vec[c]);
        end
      end
      checks++;
      if (count_obs(B_DONE) + count_obs(B_ERR) != 0) begin
        errors++; $display("FAIL abort%0d_status: got %0d done/error pulses want 0", t,
                           count_obs(B_DONE) + count_obs(B_ERR));
      end
    end
    checks++;
    if (obs_vec[exp_abort_c + 1][12:11] !== 2'b01) begin
      errors++; $display("FAIL abort_wait_opmode: got %b want 01", obs_vec[exp_abort_c + 1][12:11]);
    end
  endtask

  task automatic test_zero_len();
    int dc, nv;
    clear_seqs();
    build_model(0, NO_ABORT);
    run_dut(0, 1'b0);
    for (int c = 0; c < n_run; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++; $display("FAIL zero_len cycle %0d: got %h want %h", c, obs_vec[c], exp_vec[c]);
      end
    end
    dc = first_obs(B_DONE);
    nv = count_obs(B_TXV);
    checks++;
    if (dc != 2) begin errors++; $display("FAIL zero_len_done: got %0d want 2", dc); end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL zero_len_txvalid: got %0d cycles want 0", nv); end
  endtask

  task automatic test_reset_mid_send();
    logic [13:0] v;
    I_start = 1'b1; I_len = 7'd20; fe_rxactive = 1'b0; fe_txrdy = 1'b1;
    tick();
    I_start = 1'b0;
    repeat (12) tick();
    checks++;
    if (O_txvalid !== 1'b1) begin errors++; $display("FAIL mid_send_pre: txvalid got %b want 1", O_txvalid); end
    #2 reset_i = 1'b0;
    #1 v = cur_vec();
    checks++;
    if (v !== IDLE_VEC) begin errors++; $display("FAIL mid_send_reset: got %h want %h", v, IDLE_VEC); end
    tick();
    reset_i = 1'b1;
    fe_txrdy = 1'b0;
    tick();
    // Buffer contents survive reset: the next packet still reads the old bytes.
    clear_seqs();
    build_model(5, NO_ABORT);
    run_dut(5, 1'b0);
    for (int c = 0; c < n_run; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++; $display("FAIL after_reset cycle %0d: got %h want %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_busy_ignored();
    load_random(6);
    for (int pass = 0; pass < 2; pass++) begin
      clear_seqs();
      build_model(6, NO_ABORT);
      run_dut(6, pass == 0);
      for (int c = 0; c < n_run; c++) begin
        checks++;
        if (obs_vec[c] !== exp_vec[c]) begin
          errors++; $display("FAIL busy_ignored%0d cycle %0d: got %h want %h", pass, c, obs_vec[c], exp_vec[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    int len, arel;
    load_random(BUF);
    for (int it = 0; it < 14; it++) begin
      clear_seqs();
      for (int k = 0; k < MAXC; k++) rdy_seq[k] = ($urandom % 4) != 0;
      for (int k = 1; k < 40; k++) rx_seq[k] = ($urandom % 4) == 0;
      len  = (it == 0) ? 100 : int'($urandom_range(0, 70));
      arel = (($urandom % 4) == 0) ? int'($urandom_range(0, 76)) - 6 : NO_ABORT;
      if (it == 0) arel = NO_ABORT;
      if (($urandom % 3) == 0) write_byte(int'($urandom_range(0, BUF - 1)), 8'($urandom));
      build_model(len, arel);
      run_dut(len, 1'b0);
      for (int c = 0; c < n_run; c++) begin
        checks++;
        if (obs_vec[c] !== exp_vec[c]) begin
          errors++; $display("FAIL random%0d len %0d cycle %0d: got %h want %h", it, len, c, obs_vec[c], exp_vec[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_txrdy_toggle();
    test_rx_restart();
    test_timeout();
    test_abort();
    test_zero_len();
    test_reset_mid_send();
    test_busy_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_pw_utmi_tx
